// File: rtl/interrupt_ctrl.sv
// Three-level prioritised interrupt controller.
// Captures rising edges on inter1..inter3, arbitrates the highest eligible
// pending level against the innermost level in service, and presents a single
// request plus handler vector to the core. Nested in-service levels allow a
// higher level to preempt a lower one; ERET retires the innermost level.
module interrupt_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0040,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inter1,
    input  logic             inter2,
    input  logic             inter3,
    input  logic             ie,
    input  logic [2:0]       int_mask,
    input  logic             int_ack,
    input  logic             eret,
    output logic             int_req,
    output logic [1:0]       int_level,
    output logic [31:0]      int_vector,
    output logic             inter_running1,
    output logic             inter_running2,
    output logic             inter_running3,
    output logic [CNT_W-1:0] dropped_cnt
);

    // Bit k of each [3:1] vector corresponds to level k.
    logic [3:1] prev;
    logic [3:1] pending;
    logic [3:1] in_service;
    logic [3:1] inter_v;
    logic [3:1] edge_v;
    logic [3:1] eligible;
    logic [3:1] ack_bit;
    logic [3:1] eret_bit;
    logic [3:1] merged;
    logic [1:0] cur_pri;
    logic [1:0] best;
    logic [1:0] drop_inc;
    logic       ack_take;
    logic       level_masked;

    // Index of the highest set bit, 0 when none is set.
    function automatic logic [1:0] highest(input logic [3:1] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    // One-hot bit for a level; level 0 maps to no bit.
    function automatic logic [3:1] level_bit(input logic [1:0] lvl);
        case (lvl)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Handler address for a level, wrapping modulo 2^32.
    function automatic logic [31:0] vec_of(input logic [1:0] lvl);
        logic [31:0] idx;
        idx = {30'd0, lvl} - 32'd1;
        return VEC_BASE + idx * VEC_STRIDE;
    endfunction

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign inter_v      = {inter3, inter2, inter1};
    assign edge_v       = inter_v & ~prev;
    assign cur_pri      = highest(in_service);
    assign eligible     = pending & ~int_mask & {3{ie}};
    assign best         = highest(eligible);
    assign ack_take     = int_ack & int_req;
    assign ack_bit      = ack_take ? level_bit(int_level) : 3'b000;
    assign eret_bit     = eret ? level_bit(cur_pri) : 3'b000;
    // An edge on the level being acknowledged re-arms it rather than merging.
    assign merged       = edge_v & pending & ~ack_bit;
    assign drop_inc     = {1'b0, merged[1]} + {1'b0, merged[2]} + {1'b0, merged[3]};
    assign level_masked = |(level_bit(int_level) & int_mask);

    assign inter_running1 = in_service[1];
    assign inter_running2 = in_service[2];
    assign inter_running3 = in_service[3];

    // Input history and pending flags: a fresh edge always wins over an ack clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            prev    <= 3'b000;
            pending <= 3'b000;
        end else begin
            prev    <= inter_v;
            pending <= edge_v | (pending & ~ack_bit);
        end
    end

    // In-service nesting: ERET retires the innermost level, ack enters the new one.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            in_service <= 3'b000;
        end else begin
            in_service <= (in_service & ~eret_bit) | ack_bit;
        end
    end

    // Request handshake: raise on a winning level, freeze while up, drop on ack or withdraw.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            int_req    <= 1'b0;
            int_level  <= 2'd0;
            int_vector <= 32'd0;
        end else if (int_req) begin
            if (int_ack || !ie || level_masked) begin
                int_req   <= 1'b0;
                int_level <= 2'd0;
            end
        end else if ((best > cur_pri) && !int_ack && !eret) begin
            int_req    <= 1'b1;
            int_level  <= best;
            int_vector <= vec_of(best);
        end
    end

    // Saturating count of request edges merged into an already-pending level.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dropped_cnt <= '0;
        end else begin
            dropped_cnt <= sat_add(dropped_cnt, drop_inc);
        end
    end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Three-level prioritised interrupt controller sitting directly upstream of the CPU core's exception entry logic.
- Captures inter1..inter3 request edges from the top level, arbitrates by priority (3 highest) against the level currently in service, and presents one request with a handler vector to the core.
- Tracks nested in-service levels so a higher level may preempt a lower one; ERET retires the innermost level.
- Drives the inter_running1..3 status outputs.

Parameters:
- VEC_BASE, 32'h0000_0100, handler address for level 1.
- VEC_STRIDE, 32'h0000_0040, address step between consecutive level handlers.
- CNT_W, 8, width of the saturating dropped-request counter.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- inter1  in  1  level-1 request (lowest priority); edge-detected.
- inter2  in  1  level-2 request; edge-detected.
- inter3  in  1  level-3 request (highest priority); edge-detected.
- ie  in  1  global interrupt enable from the core.
- int_mask  in  3  per-level mask; bit k-1 = 1 masks level k.
- int_ack  in  1  one-cycle pulse: core has taken the presented interrupt.
- eret  in  1  one-cycle pulse: core executed ERET.
- int_req  out  1  interrupt request to core.
- int_level  out  2  level being requested (1..3; 0 when int_req=0).
- int_vector  out  32  handler address for int_level.
- inter_running1  out  1  level 1 in service.
- inter_running2  out  1  level 2 in service.
- inter_running3  out  1  level 3 in service.
- dropped_cnt  out  CNT_W  saturating count of merged (lost) request edges.

Behaviour:
- Reset (clr=0, async): pending, in_service and input history regs = 0; int_req=0, int_level=0, int_vector=0, inter_running1..3=0, dropped_cnt=0.
- Edge capture: prev_k registers inter_k each clk. At edge t, inter_k=1 and prev_k=0 sets pending[k] at t. Pulses not spanning a rising edge are not seen.
- Merge: a new edge on level k while pending[k]=1 leaves pending set and increments dropped_cnt, which saturates at all-ones. Simultaneous edges on several levels each handled independently; dropped_cnt increments once per merged level (up to +3 in one cycle).
- cur_pri = index of highest set in_service bit; 0 if none.
- Eligible set = pending & ~int_mask, gated by ie. best = highest eligible level.
- Request: when int_req=0, best > cur_pri, and no ack/eret this cycle, then at next edge:
  - int_req=1
  - int_level=best
  - int_vector = VEC_BASE + (best-1)*VEC_STRIDE (32-bit, wraps modulo 2^32).
  - Request latency: 2 clk edges after the first edge sampling inter_k high.
- Stability: int_level and int_vector are frozen while int_req=1. A higher level arriving meanwhile is presented only after the current handshake completes.
- Withdraw: if ie falls or int_level becomes masked while int_req=1 and no ack, int_req drops next edge; pending stays set.
- Ack: int_ack with int_req=1 clears pending[int_level] and sets in_service[int_level] at that edge. int_req=0 and int_level=0 next cycle. int_vector holds its last value. int_ack with int_req=0 is ignored.
- ERET: clears in_service[cur_pri], using in_service as it was before the edge. ERET with in_service=0 is ignored.
- Ack and eret in the same cycle: both apply. Eret clears the old highest bit; ack sets the new level.
- A new edge on the ack'd level in the same cycle as the ack leaves pending[k]=1 (set wins) and is not counted as dropped.
- Re-request after eret: pending levels now above the new cur_pri are requested per the rules above.
- Outputs inter_runningk = in_service[k], registered.
- Preemption: if in_service={1}, pending 3 → request level 3. If in_service={3}, a pending 1 waits until level 3 retires.

Test Plan:
- clr=0 mid-operation (int_req=1, in_service=3'b011) → all outputs 0 immediately, without waiting for clk; after release, nothing is requested.
- ie=1, no mask, inter1 pulsed high for one edge → int_req=1, int_level=1, int_vector=32'h100 two edges later. int_ack → inter_running1=1, int_req=0. eret → inter_running1=0.
- Level 1 in service, then inter3 pulse → int_req, int_level=3, vector 32'h180. After ack, running1=running3=1. First eret clears running3 only; second eret clears running1.
- Level 3 in service, inter1 pulse → no int_req. eret → level 1 requested two edges later (int_level=1).
- inter2 pulses at cycles 5 and 7 with no ack → single pending, dropped_cnt=1. 256 merged edges → dropped_cnt stays 8'hFF.
- int_mask=3'b100, inter3 pulse → no request. Clear mask → int_req with int_level=3. ie=0 while int_req=1 → int_req drops next edge and pending[3] is retained.
